fpmult_gen: RTL and testbench
=============================

FPMULT_GEN -- requirements
Module: fpmult_gen

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (min 4).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width without the hidden bit (min 4).
REQ-003 SHALL have parameter ROUND_NE, default 1; 1 = round-to-nearest-even, 0 = truncate.
REQ-004 SHALL define W = 1+EXP_W+MAN_W and bias B = 2^(EXP_W-1)-1; the operand format is {sign, exp, man}.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request; sampled only in IDLE.
REQ-008 dataa  input  W  operand A; sampled on the edge that accepts start.
REQ-009 datab  input  W  operand B; sampled on the edge that accepts start.
REQ-010 result  output  W  product; held stable from done until the next done.
REQ-011 done  output  1  one-cycle pulse; result and flags are valid in that cycle.
REQ-012 busy  output  1  high from the accepting edge until the done cycle, inclusive.
REQ-013 flags  output  3  {invalid, overflow, underflow}; updated with done and held with result.

Function
REQ-014 SHALL implement FSM states IDLE, UNPACK, MULT, NORM, RND and DONE.
REQ-015 SHALL, in IDLE with start=1, capture both operands, set busy and go to UNPACK; start outside IDLE SHALL be ignored.
REQ-016 SHALL, in UNPACK, compute sign = signA XOR signB and the signed exponent sum eA+eB-B in EXP_W+2 bits, and classify each operand as zero, inf, NaN or normal.
REQ-017 SHALL treat an operand with exp=0 (zero or subnormal) as zero.
REQ-018 SHALL handle special cases from UNPACK straight to DONE, in priority order:
- NaN operand, or inf*zero -> canonical qNaN {0, all-ones exp, man MSB=1, rest 0}, invalid=1.
- inf*(inf or normal) -> signed inf.
- zero*(zero or normal) -> signed zero with all flags 0.
REQ-019 SHALL, in MULT, form the (2*MAN_W+2)-bit product of the two hidden-bit mantissas by iterative shift-add, one multiplier bit per cycle, over exactly MAN_W+1 cycles.
REQ-020 SHALL, in NORM, shift right by one and increment the exponent when the product MSB is 1, then extract MAN_W mantissa bits, a guard bit and a sticky bit (OR of all lower bits).
REQ-021 SHALL, in RND with ROUND_NE=1, add 1 ulp when guard AND (sticky OR lsb); a mantissa carry-out SHALL renormalise (mantissa=0, exponent+1); ROUND_NE=0 SHALL truncate.
REQ-022 SHALL, when the final biased exponent is >= 2^EXP_W-1, output signed inf with overflow=1.
REQ-023 SHALL, when the final biased exponent is <= 0, output signed zero with underflow=1 (flush-to-zero, no subnormal output).
REQ-024 SHALL, in DONE, assert done for one cycle, deassert busy on the next edge and return to IDLE; start in the DONE cycle SHALL be ignored.
REQ-025 SHALL have latency, from the accepting edge to the edge that raises done, of MAN_W+5 cycles for normal operands (28 at defaults) and 2 cycles for special cases.
REQ-026 SHALL keep busy=1 throughout, so back-to-back operations are spaced by at least one IDLE cycle.

Reset
REQ-027 SHALL, while reset=0, immediately force the state to IDLE and result=0, flags=0, done=0, busy=0.
REQ-028 SHALL abort any operation in progress when reset is asserted mid-operation, and SHALL never produce a done pulse for the aborted operation after reset is released.

Verification (defaults, ROUND_NE=1 unless noted)
REQ-029 Start with 0x40000000*0x40400000 -> result 0x40C00000, flags 000, done 28 cycles after accept; with 0xC0000000*0x40400000 -> 0xC0C00000.
REQ-030 Start with 0x3F800001*0x3FC00000 (rounding tie) -> 0x3FC00002; with ROUND_NE=0 -> 0x3FC00001; 0x3F800001*0x3F800001 -> 0x3F800002.
REQ-031 Start with 0x7F000000*0x40000000 -> 0x7F800000, overflow=1; start with 0x00800000*0x3F000000 -> 0x00000000, underflow=1.
REQ-032 Start with 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1, done 2 cycles after accept; start with 0xFF800000*0x40000000 -> 0xFF800000, flags 000.
REQ-033 Pulse start while busy, then assert reset=0 at cycle 10 of an operation -> outputs 0 immediately, no done pulse follows, and a fresh start after release completes correctly.

Source files
------------

// File: rtl/fpmult_gen.sv
// Sequential IEEE-style floating-point multiplier with a shift-add mantissa
// datapath, flush-to-zero for subnormals and optional round-to-nearest-even.
module fpmult_gen #(
   parameter int EXP_W    = 8,
   parameter int MAN_W    = 23,
   parameter int ROUND_NE = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   dataa,
   input  logic [EXP_W+MAN_W:0]   datab,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   done,
   output logic                   busy,
   output logic [2:0]             flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int XW = EXP_W + 2;
   localparam int CW = $clog2(MAN_W + 1);
   localparam logic signed [XW-1:0] BIAS_X  = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      MULT   = 3'd2,
      NORM   = 3'd3,
      RND    = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t state, state_n;

   logic [W-1:0]            op_a, op_b;
   logic                    sign;
   logic signed [XW-1:0]    exp_acc;
   logic [PW-1:0]           mcand;
   logic [MAN_W:0]          mplier;
   logic [PW-1:0]           prod;
   logic [CW-1:0]           count;
   logic [MAN_W-1:0]        man_n;
   logic                    guard, sticky;

   logic [EXP_W-1:0]        exp_a, exp_b;
   logic [MAN_W-1:0]        man_a, man_b;
   logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
   logic                    special, sgn;
   logic [PW-2:0]           norm_frac;
   logic                    round_up;
   logic [MAN_W:0]          man_inc;
   logic [MAN_W-1:0]        man_r;
   logic signed [XW-1:0]    exp_r;

   // Operand classification; subnormals are treated as zero
   always_comb begin
      exp_a   = op_a[W-2:MAN_W];
      exp_b   = op_b[W-2:MAN_W];
      man_a   = op_a[MAN_W-1:0];
      man_b   = op_b[MAN_W-1:0];
      sgn     = op_a[W-1] ^ op_b[W-1];
      zero_a  = (exp_a == '0);
      zero_b  = (exp_b == '0);
      nan_a   = (&exp_a) && (|man_a);
      nan_b   = (&exp_b) && (|man_b);
      inf_a   = (&exp_a) && !(|man_a);
      inf_b   = (&exp_b) && !(|man_b);
      special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
   end

   // Normalisation places the leading one just above the stored fraction
   always_comb begin
      norm_frac = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      man_inc   = {1'b0, man_n} + (MAN_W+1)'(1);
      round_up  = (ROUND_NE != 0) && guard && (sticky || man_n[0]);
      man_r     = round_up ? man_inc[MAN_W-1:0] : man_n;
      exp_r     = exp_acc + XW'(round_up && man_inc[MAN_W]);
   end

   always_comb begin
      state_n = state;
      busy    = (state != IDLE);
      done    = (state == DONE);
      case (state)
         IDLE:    if (start) state_n = UNPACK;
         UNPACK:  state_n = special ? DONE : MULT;
         MULT:    if (count == CW'(MAN_W)) state_n = NORM;
         NORM:    state_n = RND;
         RND:     state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Datapath: result and flags are only written on the way into DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_a    <= '0;
         op_b    <= '0;
         sign    <= 1'b0;
         exp_acc <= '0;
         mcand   <= '0;
         mplier  <= '0;
         prod    <= '0;
         count   <= '0;
         man_n   <= '0;
         guard   <= 1'b0;
         sticky  <= 1'b0;
         result  <= '0;
         flags   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_a <= dataa;
                  op_b <= datab;
               end
            end
            UNPACK: begin
               sign    <= sgn;
               exp_acc <= XW'(exp_a) + XW'(exp_b) - BIAS_X;
               mcand   <= PW'({1'b1, man_a});
               mplier  <= {1'b1, man_b};
               prod    <= '0;
               count   <= '0;
               if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
                  result <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                  flags  <= 3'b100;
               end else if (inf_a || inf_b) begin
                  result <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  flags  <= 3'b000;
               end else if (zero_a || zero_b) begin
                  result <= {sgn, {(W-1){1'b0}}};
                  flags  <= 3'b000;
               end
            end
            MULT: begin
               if (mplier[0]) prod <= prod + mcand;
               mcand  <= {mcand[PW-2:0], 1'b0};
               mplier <= {1'b0, mplier[MAN_W:1]};
               count  <= count + CW'(1);
            end
            NORM: begin
               exp_acc <= exp_acc + XW'(prod[PW-1]);
               man_n   <= norm_frac[PW-2:MAN_W+1];
               guard   <= norm_frac[MAN_W];
               sticky  <= |norm_frac[MAN_W-1:0];
            end
            RND: begin
               if (exp_r >= EXP_TOP) begin
                  result <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  flags  <= 3'b010;
               end else if (exp_r <= 0) begin
                  result <= {sign, {(W-1){1'b0}}};
                  flags  <= 3'b001;
               end else begin
                  result <= {sign, exp_r[EXP_W-1:0], man_r};
                  flags  <= 3'b000;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpmult_gen.sv
// Scoreboard bench: randomized and directed single-precision products against
// a plain-arithmetic reference model, for rounding and truncating instances.
module tb_fpmult_gen;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  fl;
      logic [31:0] res_t;
      logic [2:0]  fl_t;
      int          lat;
      int          acc_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic [31:0] result, result_t;
   logic        done, done_t, busy, busy_t;
   logic [2:0]  flags, flags_t;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];

   fpmult_gen #(.EXP_W(8), .MAN_W(23), .ROUND_NE(1)) dut (
      .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
      .result(result), .done(done), .busy(busy), .flags(flags)
   );

   fpmult_gen #(.EXP_W(8), .MAN_W(23), .ROUND_NE(0)) dut_trunc (
      .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
      .result(result_t), .done(done_t), .busy(busy_t), .flags(flags_t)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference product from the arithmetic definition of the format
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit rne,
                                 output logic [31:0] r, output logic [2:0] fl, output int lat);
      int ea, eb, e;
      longint unsigned ma, mb, p, mant, rest;
      logic s;
      bit za, zb, ia, ib, na, nb;
      logic [31:0] ev;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = 64'(a[22:0]);
      mb = 64'(b[22:0]);
      s  = a[31] ^ b[31];
      za = (ea == 0);
      zb = (eb == 0);
      na = (ea == 255) && (ma != 0);
      nb = (eb == 255) && (mb != 0);
      ia = (ea == 255) && (ma == 0);
      ib = (eb == 255) && (mb == 0);
      lat = 2;
      if (na || nb || (ia && zb) || (za && ib)) begin
         r = 32'h7FC00000; fl = 3'b100; return;
      end
      if (ia || ib) begin
         r = {s, 8'hFF, 23'h0}; fl = 3'b000; return;
      end
      if (za || zb) begin
         r = {s, 31'h0}; fl = 3'b000; return;
      end
      lat = 28;
      p = (ma + 64'h800000) * (mb + 64'h800000);
      e = ea + eb - 127;
      if ((p >> 47) != 0) e = e + 1;
      else                p = p << 1;
      mant = (p >> 24) & 64'h7FFFFF;
      rest = p & 64'hFFFFFF;
      if (rne && ((rest > 64'h800000) || ((rest == 64'h800000) && ((mant % 2) == 1))))
         mant = mant + 1;
      if (mant == 64'h800000) begin
         mant = 0;
         e = e + 1;
      end
      if (e >= 255) begin
         r = {s, 8'hFF, 23'h0}; fl = 3'b010;
      end else if (e <= 0) begin
         r = {s, 31'h0}; fl = 3'b001;
      end else begin
         ev = 32'(e);
         r  = {s, ev[7:0], 23'(mant)};
         fl = 3'b000;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Issue one operation (called at a negedge) and push its expectation
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   w, lat_t;
      w = 0;
      while (busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (!busy) n_pass++;
      else $display("[TB] FAIL idle_wait: busy still %b after %0d cycles, expected 0", busy, w);
      dataa = a;
      datab = b;
      start = 1'b1;
      e.a = a;
      e.b = b;
      model(a, b, 1'b1, e.res, e.fl, e.lat);
      model(a, b, 1'b0, e.res_t, e.fl_t, lat_t);
      e.acc_cyc = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      dataa = $urandom;
      datab = $urandom;
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (reset && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_done: done=1 with no operation outstanding, expected 0");
         end else begin
            e = sb.pop_front();
            checkOutput($sformatf("result %h*%h", e.a, e.b), result, e.res);
            checkOutput($sformatf("flags %h*%h", e.a, e.b), 32'(flags), 32'(e.fl));
            checkOutput($sformatf("latency %h*%h", e.a, e.b), 32'(cyc - e.acc_cyc), 32'(e.lat));
            checkOutput("busy_in_done", 32'(busy), 32'd1);
            checkOutput("trunc_done", 32'(done_t), 32'd1);
            checkOutput($sformatf("trunc_result %h*%h", e.a, e.b), result_t, e.res_t);
            checkOutput($sformatf("trunc_flags %h*%h", e.a, e.b), 32'(flags_t), 32'(e.fl_t));
         end
      end
   end

   function automatic logic [31:0] randOperand();
      logic [31:0] v;
      logic [31:0] sp [4];
      sp[0] = 32'h00000000;
      sp[1] = 32'h7F800000;
      sp[2] = 32'h7FA00001;
      sp[3] = 32'h00012345;
      case ($urandom_range(0, 3))
         0:       v = $urandom;
         1:       v = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
         2:       v = sp[$urandom_range(0, 3)] | {1'($urandom), 31'h0};
         default: v = {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom) & 23'h7F0000};
      endcase
      return v;
   endfunction

   initial begin
      logic [31:0] dir_a [9];
      logic [31:0] dir_b [9];
      int w;
      dir_a = '{32'h40000000, 32'hC0000000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                32'h00800000, 32'h7F800000, 32'hFF800000, 32'h3FFFFFFF};
      dir_b = '{32'h40400000, 32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h40000000,
                32'h3F000000, 32'h00000000, 32'h40000000, 32'h3FFFFFFF};

      repeat (3) @(negedge clk);
      checkOutput("reset_result", result, 32'h0);
      checkOutput("reset_flags", 32'(flags), 32'h0);
      checkOutput("reset_done", 32'(done), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) applyStimulus(dir_a[i], dir_b[i]);

      // Start raised during the done cycle must be ignored
      w = 0;
      while (!done && w < 60) begin
         @(negedge clk);
         w++;
      end
      start = 1'b1;
      dataa = 32'h40000000;
      datab = 32'h40000000;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 40; i++) applyStimulus(randOperand(), randOperand());

      // Abort mid-operation: spurious start at cycle 5, reset at cycle 10
      applyStimulus(32'h40490FDB, 32'h402DF854);
      repeat (4) @(negedge clk);
      start = 1'b1;
      dataa = 32'h3F800000;
      datab = 32'h3F800000;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      sb.delete();
      #1;
      checkOutput("abort_result", result, 32'h0);
      checkOutput("abort_flags", 32'(flags), 32'h0);
      checkOutput("abort_done", 32'(done), 32'h0);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      checkOutput("abort_trunc_result", result_t, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("post_abort_busy", 32'(busy), 32'h0);
      applyStimulus(32'h40000000, 32'h40400000);
      applyStimulus(32'h3F800001, 32'h3FC00000);

      w = 0;
      while (sb.size() > 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("[TB] FAIL drain: %0d operations still outstanding, expected 0", sb.size());
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
